fetch_prefetch_queue: RTL and testbench

//  Instruction fetch front end for the 5-stage RV32I pipeline; replaces the direct PC -> instruction memory path.

---
 rtl/fetch_prefetch_queue.sv | 180 ++++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited requests
// to a variable-latency instruction memory, buffers returned words with their
// PCs and hands them to the IF/ID register. A redirect flushes the queue and
// marks every in-flight response as stale so it is dropped on return.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
);
    localparam int unsigned    PW       = $clog2(DEPTH);
    localparam int unsigned    CW       = PW + 1;
    localparam int unsigned    OW       = $clog2(MAX_OUTST + 1);
    localparam int unsigned    TW       = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [TW-1:0]  TAG_LAST = TW'(MAX_OUTST - 1);
    localparam logic [31:0]    NOP      = 32'h00000013;

    // RUN: responses are live; DRAIN: stale responses still in flight
    typedef enum logic {
        RUN,
        DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] tag_wr_q, tag_wr_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d;
    logic [31:0]   last_pc_q, last_pc_d;
    logic          started_q;

    // Queue storage and the in-order PC tag FIFO (no reset needed)
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   tag_pc [MAX_OUTST];

    logic          grant;
    logic          push;
    logic          pop;
    logic [31:0]   credit_use;
    logic          redirect_pc_lsb_unused;

    // Redirect targets are word aligned; the low bits are dropped
    assign redirect_pc_lsb_unused = ^redirect_pc[1:0];
    assign imem_addr              = fetch_pc_q;

    // Next-state and output logic; redirect overrides push, pop and grant
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        last_pc_d  = last_pc_q;

        // Live (non-stale) in-flight requests plus stored words must fit the queue
        credit_use = 32'(outst_q) - 32'(discard_q) + 32'(count_q);
        imem_req   = started_q && (credit_use < 32'(DEPTH))
                     && (32'(outst_q) < 32'(MAX_OUTST)) && !redirect;
        grant      = imem_req && imem_gnt;

        dec_valid  = (count_q != '0);
        dec_inst   = dec_valid ? q_inst[rd_ptr_q] : NOP;
        dec_pc     = dec_valid ? q_pc[rd_ptr_q] : last_pc_q;

        pop        = dec_valid && dec_ready && !redirect;
        push       = imem_rvalid && (state_q == RUN) && !redirect;

        if (dec_valid) begin
            last_pc_d = q_pc[rd_ptr_q];
        end

        // Outstanding and tag FIFO track the memory, independent of flushing
        outst_d = outst_q + OW'(grant) - OW'(imem_rvalid);
        if (grant) begin
            tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TW'(1);
        end
        if (imem_rvalid) begin
            tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TW'(1);
        end

        if (redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // Everything still in flight after this edge is stale
            discard_d  = outst_q + OW'(grant) - OW'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid && (state_q == DRAIN)) begin
                discard_d = discard_q - OW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        state_d = (discard_d != '0) ? DRAIN : RUN;
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            last_pc_q  <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            last_pc_q  <= last_pc_d;
            started_q  <= 1'b1;
        end
    end

    // Write returned word with the PC tag of its request into the queue
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr_q] <= imem_rdata;
            q_pc[wr_ptr_q]   <= tag_pc[tag_rd_q];
        end
    end

    // Record the address of each granted request in issue order
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_pc[tag_wr_q] <= fetch_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count_q == CW'(DEPTH))));
    a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rvalid && (outst_q == '0)));
    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst)
        imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed and random steps driven against a
// queue-based reference of the fetch front end and an in-order memory model.
module tb_fetch_prefetch_queue;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h00000000;
    localparam logic [31:0] NOP       = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUTST(MAX_OUTST),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_inst   (dec_inst),
        .dec_pc     (dec_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    pend_t       pending[$];
    ent_t        mq[$];
    int          m_discard;
    logic [31:0] m_fpc;
    logic [31:0] m_last_pc;
    bit          m_run;
    int          cyc;
    int          lat;
    int          jit;
    int          n_cmp;
    int          n_mis;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'h5A5A0000) * 32'h00010003) + 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic reset_model();
        pending.delete();
        mq.delete();
        m_discard = 0;
        m_fpc     = RESET_PC;
        m_last_pc = 32'h0;
        m_run     = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},   32'(imem_req),  32'h0);
        chk({tag, "_addr"},  imem_addr,      RESET_PC);
        chk({tag, "_valid"}, 32'(dec_valid), 32'h0);
        chk({tag, "_inst"},  dec_inst,       NOP);
        chk({tag, "_pc"},    dec_pc,         32'h0);
    endtask

    // Starts just after a rising edge; asserts reset asynchronously mid-cycle
    task automatic do_reset(input string tag);
        rst         = 1'b0;
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        dec_ready   = 1'b0;
        #1;
        check_reset(tag);
        reset_model();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare at falling edge, advance model at rising edge
    task automatic do_cycle(input bit rdy, input bit gnt, input bit redir, input logic [31:0] rpc);
        bit          rv;
        bit          e_req;
        bit          e_valid;
        bit          g;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        int          live;
        pend_t       item;

        rv          = (pending.size() > 0) && (pending[0].due <= cyc + 1);
        dec_ready   = rdy;
        imem_gnt    = gnt;
        redirect    = redir;
        redirect_pc = rpc;
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(pending[0].addr) : $urandom;

        live    = pending.size() - m_discard;
        e_req   = m_run && (live + mq.size() < DEPTH) && (pending.size() < MAX_OUTST) && !redir;
        e_valid = (mq.size() > 0);
        e_inst  = e_valid ? mq[0].inst : NOP;
        e_pc    = e_valid ? mq[0].pc : m_last_pc;

        @(negedge clk);
        chk("imem_req",  32'(imem_req),  32'(e_req));
        chk("imem_addr", imem_addr,      m_fpc);
        chk("dec_valid", 32'(dec_valid), 32'(e_valid));
        chk("dec_inst",  dec_inst,       e_inst);
        chk("dec_pc",    dec_pc,         e_pc);

        @(posedge clk);
        cyc++;
        g = e_req && gnt;
        if (e_valid) m_last_pc = e_pc;
        if (redir) begin
            m_discard = pending.size() + (g ? 1 : 0) - (rv ? 1 : 0);
            mq.delete();
            m_fpc = {rpc[31:2], 2'b00};
            if (rv) void'(pending.pop_front());
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (rv) begin
                item = pending.pop_front();
                if (m_discard > 0) m_discard--;
                else mq.push_back('{mem_word(item.addr), item.addr});
            end
            if (g) begin
                pending.push_back('{m_fpc, cyc + lat + int'($urandom_range(0, jit))});
                m_fpc = m_fpc + 32'd4;
            end
        end
        m_run = 1'b1;
        #1;
    endtask

    initial begin
        n_cmp       = 0;
        n_mis       = 0;
        cyc         = 0;
        lat         = 1;
        jit         = 0;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        dec_ready   = 1'b0;
        reset_model();

        // Reset values, then release between edges
        #1;
        check_reset("reset");
        @(posedge clk);
        @(posedge clk);
        cyc = 2;
        #1;
        check_reset("reset_hold");
        rst = 1'b1;

        // Streaming at latency 1 with the decoder always ready
        repeat (12) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Decoder stalls: queue fills and requests stop, then drains
        repeat (10) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Memory withholds grant: address must hold
        repeat (3) do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (6) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Latency 3 with requests in flight, redirect to an unaligned target
        lat = 3;
        repeat (4) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h00000107);
        repeat (12) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect near the top of the address space: fetch PC wraps to zero
        lat = 1;
        do_cycle(1'b1, 1'b1, 1'b1, 32'hFFFFFFF9);
        repeat (8) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect with a full queue and the decoder ready in the same cycle
        lat = 2;
        repeat (10) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h00000200);
        repeat (8) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Back-to-back redirects while stale responses are still pending
        lat = 4;
        repeat (3) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h00000300);
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h00000400);
        repeat (12) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Random traffic with variable latency, with a reset in the middle
        jit = 2;
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) lat = $urandom_range(1, 4);
            if (i == 300) do_reset("mid_reset");
            do_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 24) == 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
